fp_div_arbiter: RTL and testbench
=================================

Name: fp_div_arbiter

Overview:
Shares a single pipelined floating-point divider IP (single-precision, in-order, non-blocking result channel) between N_REQ requesters. It applies round-robin arbitration on the operand side and registers the winning operand pair into the divider input. A tag FIFO records the requester index of every issued operation, so each in-order result is routed back to its originator. It sits between the vector drivers and the divider inside the top-level FP-divide wrapper.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index, = clog2(N_REQ)
MAX_INFLIGHT, 32, tag FIFO depth = max operations outstanding in divider (power of 2, >= divider latency+2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester operand pair valid
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
req_a  in  32*N_REQ  dividend, requester i at [32*i+:32]
req_b  in  32*N_REQ  divisor, requester i at [32*i+:32]
div_in_valid  out  1  operand pair valid to divider (drives both a/b tvalid)
div_in_ready  in  1  divider accepts (AND of a/b tready)
div_a  out  32  dividend to divider
div_b  out  32  divisor to divider
div_res_valid  in  1  divider result valid (cannot be stalled)
div_res_data  in  32  divider result
rsp_valid  out  1  routed result valid, one-cycle pulse per result
rsp_id  out  ID_W  requester index owning rsp_data
rsp_data  out  32  result
inflight  out  clog2(MAX_INFLIGHT)+1  outstanding operations
err_orphan  out  1  sticky: result arrived with tag FIFO empty

Behaviour:
- Reset (async, rst=1): div_in_valid=0, div_a=div_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, inflight=0, err_orphan=0, rr pointer=0, tag FIFO emptied. Any operation in progress is abandoned; the divider shares rst and flushes.
- Output stage is a one-entry register (div_in_valid/div_a/div_b). It can load when (!div_in_valid || div_in_ready) && inflight_next_allowed, where allowed means inflight < MAX_INFLIGHT, counting pushes not yet popped.
- Arbitration: round-robin starting at the rr pointer. The first asserted req_valid at or after the pointer wins. req_ready[win]=1 only when the stage can load; otherwise req_ready=0. The grant is combinational from registered state and req_valid.
- On accept (req_valid[i]&req_ready[i]): next edge loads div_a/div_b from requester i, sets div_in_valid=1, and sets rr pointer=(i+1) mod N_REQ. Issue latency is 1 cycle from accept to div_in_valid.
- Tag push occurs on the divider handshake (div_in_valid&div_in_ready), writing the requester index of the held pair. The stage holds the pair stable while div_in_valid&!div_in_ready.
- Result: on div_res_valid with FIFO non-empty, pop the tag. Next edge sets rsp_valid=1, rsp_id=tag, rsp_data=div_res_data. Otherwise rsp_valid=0. Response latency is 1 cycle.
- Orphan: div_res_valid with FIFO empty drops the result, sets err_orphan=1 (cleared only by rst), and leaves rsp_valid=0.
- inflight = push count minus pop count. A simultaneous push and pop leaves it unchanged. It never exceeds MAX_INFLIGHT. When full, req_ready stays 0 until a pop occurs; a pop in the same cycle does not free a slot for acceptance in that cycle.
- FIFO pointers are ID-agnostic, binary, and wrap modulo MAX_INFLIGHT.
- Results are delivered strictly in issue order across all requesters.

Test Plan:
- Single requester: req 0 sends a=0x41000000 (8.0), b=0x40000000 (2.0) -> div_in_valid one cycle after accept; rsp_valid with rsp_id=0, rsp_data=0x40800000 (4.0); inflight returns to 0.
- All 4 requesters valid continuously, div_in_ready=1 -> grants cycle 0,1,2,3,0,...; each rsp_id sequence matches issue order; no requester is starved over 16 issues.
- div_in_ready held low 5 cycles with a pair loaded -> div_a/div_b stable, req_ready all 0, no tag pushed; the pair issues on the first ready cycle.
- Stubbed divider returns nothing until MAX_INFLIGHT=32 are issued -> inflight=32, req_ready=0. The first result pops a tag, and acceptance resumes the next cycle.
- div_res_valid asserted with no issues after reset, data 0x3F800000 -> err_orphan=1, rsp_valid stays 0.
- Assert rst mid-stream with 10 inflight -> all outputs return to reset values immediately; after release, a fresh request 1.0/4.0 (0x3F800000/0x40800000) returns 0x3E800000 with the correct rsp_id.

Source files
------------

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one pipelined FP divider among N_REQ requesters.
// A tag FIFO remembers who issued each operation so in-order results return to their owner.
module fp_div_arbiter #(
    parameter int N_REQ        = 4,
    parameter int ID_W         = 2,
    parameter int MAX_INFLIGHT = 32,
    localparam int DATA_W      = 32,
    localparam int CNT_W       = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [DATA_W*N_REQ-1:0] req_a,
    input  logic [DATA_W*N_REQ-1:0] req_b,
    output logic                    div_in_valid,
    input  logic                    div_in_ready,
    output logic [DATA_W-1:0]       div_a,
    output logic [DATA_W-1:0]       div_b,
    input  logic                    div_res_valid,
    input  logic [DATA_W-1:0]       div_res_data,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [CNT_W-1:0]        inflight,
    output logic                    err_orphan
);
    localparam int AW = $clog2(MAX_INFLIGHT);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_next;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   hold_id;
    logic [ID_W:0]     cand;
    logic              win_found;
    logic [DATA_W-1:0] win_a;
    logic [DATA_W-1:0] win_b;
    logic              stage_free;
    logic              slot_ok;
    logic              accept;
    logic              push;
    logic              pop;
    logic [ID_W-1:0]   tag_mem [MAX_INFLIGHT];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign push       = div_in_valid & div_in_ready;
    assign pop        = div_res_valid & (inflight != '0);
    assign stage_free = !div_in_valid || div_in_ready;
    // The pair being handed over this cycle already owns a slot; a same-cycle pop does not free one.
    assign slot_ok    = (inflight + CNT_W'(push)) < CNT_W'(MAX_INFLIGHT);
    assign accept     = win_found && stage_free && slot_ok;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
            if (!win_found && req_valid[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_a = req_a[DATA_W*i +: DATA_W];
                win_b = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win_id] = 1'b1;
    end

    assign rr_next = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + ID_W'(1);

    // Issue stage: one-entry holding register in front of the divider
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_in_valid <= 1'b0;
            div_a        <= '0;
            div_b        <= '0;
            hold_id      <= '0;
            rr_ptr       <= '0;
        end else if (accept) begin
            div_in_valid <= 1'b1;
            div_a        <= win_a;
            div_b        <= win_b;
            hold_id      <= win_id;
            rr_ptr       <= rr_next;
        end else if (push) begin
            div_in_valid <= 1'b0;
        end
    end

    // Tag FIFO: pushed on divider handshake, popped on each owned result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            inflight <= inflight + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= hold_id;
    end

    // Response stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= pop;
            if (pop) begin
                rsp_id   <= tag_mem[rd_ptr];
                rsp_data <= div_res_data;
            end
            if (div_res_valid && (inflight == '0)) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Randomized bench for fp_div_arbiter with a stub divider and a queue-based reference model.
module tb_fp_div_arbiter;
    localparam int N_REQ        = 4;
    localparam int ID_W         = 2;
    localparam int MAX_INFLIGHT = 32;
    localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1;
    localparam int LAT          = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [32*N_REQ-1:0]   req_a;
    logic [32*N_REQ-1:0]   req_b;
    logic                  div_in_valid;
    logic                  div_in_ready;
    logic [31:0]           div_a;
    logic [31:0]           div_b;
    logic                  div_res_valid;
    logic [31:0]           div_res_data;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic [CNT_W-1:0]      inflight;
    logic                  err_orphan;

    fp_div_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .div_in_valid(div_in_valid), .div_in_ready(div_in_ready), .div_a(div_a), .div_b(div_b),
        .div_res_valid(div_res_valid), .div_res_data(div_res_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [ID_W-1:0] id; logic [31:0] a; logic [31:0] b; } op_t;
    typedef struct packed { logic [31:0] data; logic [31:0] due; } res_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   rr_m = 0;
    int   m_inflight = 0;
    bit   m_orphan = 1'b0;
    bit   exp_rsp = 1'b0;
    bit   acc_prev = 1'b0;
    op_t  exp_op;
    op_t  acc_op;
    op_t  issue_q[$];
    op_t  rsp_q[$];
    res_t div_pipe[$];
    bit          pend_v[N_REQ];
    logic [31:0] pend_a[N_REQ];
    logic [31:0] pend_b[N_REQ];
    int   req_mode = 0;   // 0 none, 1 random refill, 2 always refill
    int   rdy_mode = 0;   // 0 ready, 1 random, 2 stalled
    bit   stub_on = 1'b1;
    bit   force_res = 1'b0;
    logic [31:0] force_data = '0;
    int   grant_log[$];
    int   rsp_seen = 0;
    logic [ID_W-1:0] last_rsp_id = '0;
    logic [31:0]     last_rsp_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stub divider: true quotients for the directed pairs, a data fingerprint otherwise.
    function automatic logic [31:0] stub_div(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h41000000 && b == 32'h40000000) return 32'h40800000;
        if (a == 32'h3F800000 && b == 32'h40800000) return 32'h3E800000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic int rr_pick();
        for (int k = 0; k < N_REQ; k++) begin
            if (pend_v[(rr_m + k) % N_REQ]) return (rr_m + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < N_REQ; i++) if (pend_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        int   w;
        int   exp_w;
        bit   stage_busy;
        bit   push_now;
        bit   pop_now;
        bit   exp_any;
        op_t  op;
        res_t r;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pend_v[i] && (req_mode == 2 || (req_mode == 1 && $urandom_range(0, 3) != 0))) begin
                pend_v[i] = 1'b1;
                pend_a[i] = $urandom;
                pend_b[i] = $urandom;
            end
            req_valid[i]      = pend_v[i];
            req_a[32*i +: 32] = pend_a[i];
            req_b[32*i +: 32] = pend_b[i];
        end
        div_in_ready  = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        div_res_valid = 1'b0;
        div_res_data  = '0;
        if (force_res) begin
            div_res_valid = 1'b1;
            div_res_data  = force_data;
            force_res     = 1'b0;
        end else if (stub_on && div_pipe.size() > 0 && int'(div_pipe[0].due) <= cyc) begin
            r = div_pipe.pop_front();
            div_res_valid = 1'b1;
            div_res_data  = r.data;
        end

        @(negedge clk);
        check("inflight", inflight, m_inflight);
        check("err_orphan", err_orphan, m_orphan);
        check("rsp_valid", rsp_valid, exp_rsp);
        if (rsp_valid) begin
            rsp_seen++;
            last_rsp_id   = rsp_id;
            last_rsp_data = rsp_data;
        end
        if (exp_rsp) begin
            check("rsp_id", rsp_id, exp_op.id);
            check("rsp_data", rsp_data, stub_div(exp_op.a, exp_op.b));
        end
        stage_busy = issue_q.size() != 0;
        check("div_in_valid", div_in_valid, stage_busy);
        if (acc_prev) begin
            check("issue_a", div_a, acc_op.a);
            check("issue_b", div_b, acc_op.b);
        end
        acc_prev = 1'b0;

        push_now = stage_busy && div_in_ready;
        if (push_now) begin
            op = issue_q.pop_front();
            check("div_a", div_a, op.a);
            check("div_b", div_b, op.b);
            rsp_q.push_back(op);
            r.data = stub_div(op.a, op.b);
            r.due  = 32'(cyc + LAT);
            div_pipe.push_back(r);
        end

        exp_w   = rr_pick();
        exp_any = (exp_w >= 0) && (!stage_busy || div_in_ready)
                  && (m_inflight + int'(push_now) < MAX_INFLIGHT);
        check("ready_onehot0", $onehot0(req_ready), 1);
        check("ready_any", |req_ready, exp_any);
        if (m_inflight >= MAX_INFLIGHT) check("ready_full", req_ready, 0);
        if (req_ready != '0) begin
            w = 0;
            for (int i = 0; i < N_REQ; i++) if (req_ready[i]) w = i;
            check("grant_id", w, exp_w);
            acc_op.id = ID_W'(w);
            acc_op.a  = pend_a[w];
            acc_op.b  = pend_b[w];
            issue_q.push_back(acc_op);
            acc_prev  = 1'b1;
            pend_v[w] = 1'b0;
            rr_m      = (w + 1) % N_REQ;
            grant_log.push_back(w);
        end

        pop_now = div_res_valid && (m_inflight > 0);
        if (div_res_valid && m_inflight == 0) m_orphan = 1'b1;
        exp_rsp = pop_now;
        if (pop_now) exp_op = rsp_q.pop_front();
        m_inflight = m_inflight + int'(push_now) - int'(pop_now);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_div_in_valid", div_in_valid, 0);
        check("rst_div_a", div_a, 0);
        check("rst_div_b", div_b, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err_orphan", err_orphan, 0);
        issue_q.delete();
        rsp_q.delete();
        div_pipe.delete();
        for (int i = 0; i < N_REQ; i++) begin
            pend_v[i] = 1'b0;
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        rr_m = 0; m_inflight = 0; m_orphan = 1'b0; exp_rsp = 1'b0; acc_prev = 1'b0;
        req_mode = 0; rdy_mode = 0; stub_on = 1'b1; force_res = 1'b0;
        req_valid = '0; div_res_valid = 1'b0; div_res_data = '0; div_in_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        req_mode = 0; rdy_mode = 0; stub_on = 1'b1;
        while ((m_inflight != 0 || issue_q.size() != 0 || exp_rsp || any_pend()) && n < 400) begin
            step();
            n++;
        end
        check({tag, "_drained"}, n < 400, 1);
    endtask

    task automatic wait_rsp(input string tag, input int base);
        int n = 0;
        while (rsp_seen == base && n < 60) begin
            step();
            n++;
        end
        check({tag, "_rsp_timeout"}, n < 60, 1);
    endtask

    initial begin
        int n;
        int base;
        req_valid = '0; req_a = '0; req_b = '0;
        div_in_ready = 1'b0; div_res_valid = 1'b0; div_res_data = '0;
        do_reset();

        // Orphan result straight after reset
        force_res  = 1'b1;
        force_data = 32'h3F800000;
        repeat (3) step();
        check("orphan_sticky", err_orphan, 1);
        check("orphan_no_rsp", rsp_seen, 0);
        do_reset();

        // Single requester 8.0 / 2.0
        pend_v[0] = 1'b1; pend_a[0] = 32'h41000000; pend_b[0] = 32'h40000000;
        base = rsp_seen;
        wait_rsp("single", base);
        check("single_id", last_rsp_id, 0);
        check("single_data", last_rsp_data, 32'h40800000);
        step();
        check("single_inflight0", inflight, 0);

        // All requesters continuously valid
        do_reset();
        grant_log.delete();
        req_mode = 2; rdy_mode = 0;
        n = 0;
        while (grant_log.size() < 16 && n < 100) begin step(); n++; end
        check("rr_timeout", n < 100, 1);
        for (int k = 0; k < 16 && k < grant_log.size(); k++) check("rr_seq", grant_log[k], k % N_REQ);
        drain("rr");

        // Divider stalled with a pair held
        do_reset();
        rdy_mode = 2;
        pend_v[1] = 1'b1; pend_a[1] = 32'h40400000; pend_b[1] = 32'h3F800000;
        step();
        step();
        pend_v[0] = 1'b1; pend_a[0] = $urandom; pend_b[0] = $urandom;
        pend_v[3] = 1'b1; pend_a[3] = $urandom; pend_b[3] = $urandom;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stall_a", div_a, 32'h40400000);
            check("stall_b", div_b, 32'h3F800000);
            check("stall_ready", req_ready, 0);
            check("stall_nopush", inflight, 0);
        end
        rdy_mode = 0;
        step();
        drain("stall");

        // Fill the tag FIFO with no results returning
        do_reset();
        stub_on = 1'b0; req_mode = 2; rdy_mode = 0;
        n = 0;
        while (m_inflight < MAX_INFLIGHT && n < 200) begin step(); n++; end
        check("full_timeout", n < 200, 1);
        step();
        check("full_inflight", inflight, MAX_INFLIGHT);
        check("full_ready", req_ready, 0);
        repeat (3) step();
        stub_on = 1'b1;
        step();
        check("full_pop_no_accept", req_ready, 0);
        step();
        check("full_resume", |req_ready, 1);
        drain("full");

        // Random traffic with stalls and bursty results
        do_reset();
        req_mode = 1; rdy_mode = 1;
        for (int k = 0; k < 400; k++) begin
            stub_on = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("rand");

        // Reset with operations outstanding, then a fresh 1.0 / 4.0
        do_reset();
        stub_on = 1'b0; req_mode = 2; rdy_mode = 0;
        n = 0;
        while (m_inflight < 10 && n < 50) begin step(); n++; end
        check("prereset_timeout", n < 50, 1);
        step();
        do_reset();
        pend_v[2] = 1'b1; pend_a[2] = 32'h3F800000; pend_b[2] = 32'h40800000;
        base = rsp_seen;
        wait_rsp("postrst", base);
        check("postrst_id", last_rsp_id, 2);
        check("postrst_data", last_rsp_data, 32'h3E800000);
        drain("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
